// File: rtl/tcb_vip_pkg.sv
// Shared types and constants for the multi-port TCB memory model.
// Optional stall generation is controlled by TCB_VIP_MEM_STALL_EN.
package tcb_vip_pkg;

  // Elaboration-time configuration handed from the top to each port
  typedef struct packed {
    logic [15:0] pn;
    logic [15:0] abw;
    logic [15:0] dbw;
    logic [15:0] slw;
    logic [31:0] sz;
    logic [2:0]  dly;
    logic [3:0]  stl;
  } tcb_vip_mem_cfg_t;

  localparam tcb_vip_mem_cfg_t TCB_VIP_MEM_CFG_DEF = '{
    pn:  16'd2,
    abw: 16'd32,
    dbw: 16'd32,
    slw: 16'd8,
    sz:  32'd4096,
    dly: 3'd1,
    stl: 4'd4
  };

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10)
  localparam int unsigned LFSR_W    = 16;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/tcb_vip_mem_mp_if.sv
// Bundled TCB request/response signals for PN ports.
// Port i occupies index i of every vector.
interface tcb_vip_mem_mp_if #(
  parameter int unsigned PN  = 2,
  parameter int unsigned ABW = 32,
  parameter int unsigned DBW = 32,
  parameter int unsigned BEW = 4
) ();

  logic [PN-1:0]           vld;
  logic [PN-1:0]           rdy;
  logic [PN-1:0]           wen;
  logic [PN-1:0][ABW-1:0]  adr;
  logic [PN-1:0][BEW-1:0]  ben;
  logic [PN-1:0][DBW-1:0]  wdt;
  logic [PN-1:0][DBW-1:0]  rdt;
  logic [PN-1:0]           err;

  modport master (
    output vld, wen, adr, ben, wdt,
    input  rdy, rdt, err
  );

  modport slave (
    input  vld, wen, adr, ben, wdt,
    output rdy, rdt, err
  );

endinterface

// File: rtl/tcb_vip_mem_port.sv
// One TCB port of the memory model: read/err delay line, held read data
// and, with TCB_VIP_MEM_STALL_EN, an LFSR-driven ready.
module tcb_vip_mem_port
  import tcb_vip_pkg::*;
#(
  parameter tcb_vip_mem_cfg_t CFG = TCB_VIP_MEM_CFG_DEF
`ifdef TCB_VIP_MEM_STALL_EN
  , parameter int unsigned IDX = 0
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_c,
  input  logic                     err_c,
  input  logic [32'(CFG.dbw)-1:0]  dat_c,
  output logic                     rdy,
  output logic [32'(CFG.dbw)-1:0]  rdt,
  output logic                     err
);

  localparam int unsigned DBW = 32'(CFG.dbw);
  localparam int unsigned DLY = 32'(CFG.dly);

  typedef struct packed {
    logic           rd;
    logic           err;
    logic [DBW-1:0] dat;
  } stg_t;

  stg_t           in_c;
  stg_t           out_c;
  logic [DBW-1:0] hold_q;

  assign in_c = '{rd: rd_c, err: err_c, dat: dat_c};

  generate
    if (DLY == 0) begin : g_comb
      // zero latency: the transfer itself drives the response, muted in reset
      assign out_c = rst ? '0 : in_c;
    end else begin : g_pipe
      stg_t pipe_q [DLY];

      // read/err delay line; reset drops whatever is in flight
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < DLY; k++) pipe_q[k] <= '0;
        end else begin
          pipe_q[0] <= in_c;
          for (int k = 1; k < DLY; k++) pipe_q[k] <= pipe_q[k-1];
        end
      end

      assign out_c = pipe_q[DLY-1];
    end
  endgenerate

  // rdt keeps the last read leaving the line; writes never touch it
  always_ff @(posedge clk) begin
    if (rst)             hold_q <= '0;
    else if (out_c.rd)   hold_q <= out_c.dat;
  end

  assign rdt = out_c.rd ? out_c.dat : hold_q;
  assign err = out_c.err;

`ifdef TCB_VIP_MEM_STALL_EN
  localparam int unsigned STL = 32'(CFG.stl);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;
  logic              rdy_q;

  assign lfsr_d = lfsr_next(lfsr_q);

  // free-running LFSR; rdy_q tracks the threshold test of the current state
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED ^ 16'(IDX);
      rdy_q  <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      rdy_q  <= (lfsr_d[3:0] >= 4'(STL));
    end
  end

  assign rdy = rdy_q;
`else
  assign rdy = 1'b1;
`endif

endmodule

// File: rtl/tcb_vip_mem_mp.sv
// Multi-port TCB memory model: PN ports share one byte array.
// Define TCB_VIP_MEM_STALL_EN to enable pseudo-random backpressure.
module tcb_vip_mem_mp
  import tcb_vip_pkg::*;
#(
  parameter int unsigned PN  = 2,
  parameter int unsigned ABW = 32,
  parameter int unsigned DBW = 32,
  parameter int unsigned SLW = 8,
  parameter int unsigned SZ  = 2**12,
  parameter int unsigned DLY = 1,
  parameter int unsigned STL = 4
) (
  input  logic              clk,
  input  logic              rst,
  tcb_vip_mem_mp_if.slave   tcb
);

  localparam int unsigned BEW = DBW / SLW;
  localparam int unsigned MAW = $clog2(SZ);

  localparam tcb_vip_mem_cfg_t CFG = '{
    pn:  16'(PN),
    abw: 16'(ABW),
    dbw: 16'(DBW),
    slw: 16'(SLW),
    sz:  32'(SZ),
    dly: 3'(DLY),
    stl: 4'(STL)
  };

  logic [SLW-1:0] mem [SZ];

  logic [PN-1:0]  rdy;
  logic [PN-1:0]  trn;
  logic [PN-1:0]  oor;
  logic [PN-1:0]  err_p;
  logic [DBW-1:0] rdat_c [PN];
  logic [DBW-1:0] rdt_p  [PN];

  // byte address of lane b within the word holding adr
  function automatic logic [MAW-1:0] lane_adr(input logic [ABW-1:0] adr, input int unsigned b);
    return (adr[MAW-1:0] & ~MAW'(BEW-1)) | MAW'(b);
  endfunction

  // handshake, range test and lane-wise array read for every port
  always_comb begin
    for (int i = 0; i < PN; i++) begin
      trn[i]    = tcb.vld[i] & rdy[i];
      oor[i]    = (tcb.adr[i] >= ABW'(SZ));
      rdat_c[i] = 'x;
      for (int b = 0; b < BEW; b++) begin
        if (tcb.ben[i][b] && !oor[i]) begin
          rdat_c[i][b*SLW +: SLW] = mem[lane_adr(tcb.adr[i], b)];
        end
      end
    end
  end

  // byte writes; ports are visited high to low so port 0 wins a collision
  always_ff @(posedge clk) begin
    for (int i = PN - 1; i >= 0; i--) begin
      if (trn[i] && tcb.wen[i] && !oor[i]) begin
        for (int b = 0; b < BEW; b++) begin
          if (tcb.ben[i][b]) mem[lane_adr(tcb.adr[i], b)] <= tcb.wdt[i][b*SLW +: SLW];
        end
      end
    end
  end

  // per-port response pipeline and ready generation
  for (genvar i = 0; i < PN; i++) begin : g_port
    tcb_vip_mem_port #(
      .CFG (CFG)
`ifdef TCB_VIP_MEM_STALL_EN
      , .IDX (i)
`endif
    ) u_port (
      .clk   (clk),
      .rst   (rst),
      .rd_c  (trn[i] & ~tcb.wen[i]),
      .err_c (trn[i] & oor[i]),
      .dat_c (rdat_c[i]),
      .rdy   (rdy[i]),
      .rdt   (rdt_p[i]),
      .err   (err_p[i])
    );

    assign tcb.rdy[i] = rdy[i];
    assign tcb.rdt[i] = rdt_p[i];
  end

  assign tcb.err = err_p;

endmodule

// File: tb/tb_tcb_vip_mem_mp.sv
// Scoreboard bench for tcb_vip_mem_mp (DLY=2, PN=2).
// Stall-specific checks are compiled when TCB_VIP_MEM_STALL_EN is defined.
module tb_tcb_vip_mem_mp;

  localparam int unsigned PN  = 2;
  localparam int unsigned ABW = 32;
  localparam int unsigned DBW = 32;
  localparam int unsigned SLW = 8;
  localparam int unsigned BEW = DBW / SLW;
  localparam int unsigned SZ  = 4096;
  localparam int unsigned DLY = 2;
  localparam int unsigned STL = 8;
`ifdef TCB_VIP_MEM_STALL_EN
  localparam int NRND = 1000;
`else
  localparam int NRND = 300;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  tcb_vip_mem_mp_if #(.PN(PN), .ABW(ABW), .DBW(DBW), .BEW(BEW)) tcb ();

  tcb_vip_mem_mp #(
    .PN(PN), .ABW(ABW), .DBW(DBW), .SLW(SLW), .SZ(SZ), .DLY(DLY), .STL(STL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .tcb (tcb)
  );

  typedef struct {
    int             due;
    int             port;
    bit             rd;
    bit             err;
    bit             kon;
    logic [DBW-1:0] dat;
    logic [DBW-1:0] kval;
  } exp_t;

  exp_t           sbq [$];
  logic [SLW-1:0] mdl [SZ];
  logic [DBW-1:0] hold [PN];
  bit             hold_ok [PN];
  bit             acc [PN];
  bit             kon [PN];
  logic [DBW-1:0] kexp [PN];
  int             cyc = 0;
  int             n_asrt = 0;
  int             n_fail = 0;
  int             rdy_cnt = 0;
  int             rdy_tot = 0;
  bit             model_up = 1'b0;

  task automatic check(input string tag, input logic [DBW-1:0] obs, input logic [DBW-1:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv_idle(input int p);
    tcb.vld[p] = 1'b0;
    tcb.wen[p] = 1'b0;
    tcb.adr[p] = '0;
    tcb.ben[p] = '0;
    tcb.wdt[p] = '0;
    kon[p]     = 1'b0;
  endtask

  task automatic drv_wr(input int p, input logic [ABW-1:0] a, input logic [BEW-1:0] be, input logic [DBW-1:0] d);
    tcb.vld[p] = 1'b1;
    tcb.wen[p] = 1'b1;
    tcb.adr[p] = a;
    tcb.ben[p] = be;
    tcb.wdt[p] = d;
    kon[p]     = 1'b0;
  endtask

  task automatic drv_rd(input int p, input logic [ABW-1:0] a);
    tcb.vld[p] = 1'b1;
    tcb.wen[p] = 1'b0;
    tcb.adr[p] = a;
    tcb.ben[p] = '1;
    tcb.wdt[p] = '0;
    kon[p]     = 1'b0;
  endtask

  // read with an independently stated expected value
  task automatic drv_rdx(input int p, input logic [ABW-1:0] a, input logic [DBW-1:0] kv);
    drv_rd(p, a);
    kon[p]  = 1'b1;
    kexp[p] = kv;
  endtask

  // one clock: push accepted transfers, update model, compare outputs, advance
  task automatic tick();
    exp_t           e;
    bit             ex_v [PN];
    bit             ex_r [PN];
    bit             ex_e [PN];
    bit             ex_k [PN];
    logic [DBW-1:0] ex_d [PN];
    logic [DBW-1:0] ex_kv [PN];
    int             base;
    @(negedge clk);
    for (int p = 0; p < PN; p++) begin
      acc[p] = !rst && tcb.vld[p] && (tcb.rdy[p] === 1'b1);
`ifdef TCB_VIP_MEM_STALL_EN
      if (model_up && rst) check($sformatf("rdy_in_reset[%0d]", p), DBW'(tcb.rdy[p]), '0);
      if (model_up && !rst) begin
        rdy_tot++;
        if (tcb.rdy[p] === 1'b1) rdy_cnt++;
      end
`else
      if (model_up) check($sformatf("rdy[%0d]", p), DBW'(tcb.rdy[p]), DBW'(1));
`endif
      if (acc[p]) begin
        e.due  = cyc + DLY;
        e.port = p;
        e.rd   = !tcb.wen[p];
        e.err  = (tcb.adr[p] >= ABW'(SZ));
        e.kon  = kon[p];
        e.kval = kexp[p];
        e.dat  = 'x;
        base   = int'(tcb.adr[p] & ~ABW'(BEW-1));
        if (!e.err) begin
          for (int b = 0; b < BEW; b++)
            if (tcb.ben[p][b]) e.dat[b*SLW +: SLW] = mdl[base + b];
        end
        sbq.push_back(e);
      end
    end
    for (int p = PN - 1; p >= 0; p--) begin
      if (acc[p] && tcb.wen[p] && tcb.adr[p] < ABW'(SZ)) begin
        base = int'(tcb.adr[p] & ~ABW'(BEW-1));
        for (int b = 0; b < BEW; b++)
          if (tcb.ben[p][b]) mdl[base + b] = tcb.wdt[p][b*SLW +: SLW];
      end
    end
    for (int p = 0; p < PN; p++) begin
      ex_v[p] = 1'b0; ex_r[p] = 1'b0; ex_e[p] = 1'b0; ex_k[p] = 1'b0;
      ex_d[p] = '0;   ex_kv[p] = '0;
    end
    while (sbq.size() != 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      ex_v[e.port]  = 1'b1;
      ex_r[e.port]  = e.rd;
      ex_e[e.port]  = e.err;
      ex_d[e.port]  = e.dat;
      ex_k[e.port]  = e.kon && e.rd && !e.err;
      ex_kv[e.port] = e.kval;
    end
    if (model_up) begin
      for (int p = 0; p < PN; p++) begin
        check($sformatf("err[%0d]@%0d", p, cyc), DBW'(tcb.err[p]), DBW'(ex_v[p] && ex_e[p]));
        if (ex_v[p] && ex_r[p] && !ex_e[p]) begin
          hold[p]    = ex_d[p];
          hold_ok[p] = 1'b1;
        end else if (ex_v[p] && ex_r[p]) begin
          hold_ok[p] = 1'b0;
        end
        if (hold_ok[p]) check($sformatf("rdt[%0d]@%0d", p, cyc), tcb.rdt[p], hold[p]);
        if (ex_k[p]) check($sformatf("rdt_const[%0d]@%0d", p, cyc), tcb.rdt[p], ex_kv[p]);
      end
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      sbq.delete();
      for (int p = 0; p < PN; p++) begin
        hold[p]    = '0;
        hold_ok[p] = 1'b1;
      end
      model_up = 1'b1;
    end
    #1;
  endtask

  // tick until every requesting port has been accepted, bounded
  task automatic go();
    int n;
    n = 0;
    while (tcb.vld != '0) begin
      tick();
      for (int p = 0; p < PN; p++) if (acc[p]) drv_idle(p);
      n++;
      if (n > 64) begin
        n_asrt++;
        n_fail++;
        $error("FAIL handshake_timeout: observed %0d cycles required <= 64", n);
        for (int p = 0; p < PN; p++) drv_idle(p);
      end
    end
  endtask

  task automatic wait_n(input int k);
    repeat (k) tick();
  endtask

  initial begin
    int unsigned    r;
    logic [ABW-1:0] a;
    rst = 1'b1;
    for (int p = 0; p < PN; p++) begin
      drv_idle(p);
      acc[p]     = 1'b0;
      hold[p]    = '0;
      hold_ok[p] = 1'b0;
      kexp[p]    = '0;
    end
    wait_n(3);
    rst = 1'b0;

    // write on port 0, read back on port 1
    drv_wr(0, 32'h10, 4'hF, 32'hDEADBEEF); go();
    drv_rdx(1, 32'h10, 32'hDEADBEEF);      go();
    wait_n(4);

    // partial write over all-ones
    drv_wr(0, 32'h14, 4'hF, 32'hFFFFFFFF);    go();
    drv_wr(0, 32'h14, 4'b0101, 32'h11223344); go();
    drv_rdx(0, 32'h14, 32'hFF22FF44);         go();
    wait_n(4);

    // same-cycle collision: lowest port wins
    drv_wr(0, 32'h20, 4'hF, 32'hAAAAAAAA);
    drv_wr(1, 32'h20, 4'hF, 32'h55555555); go();
    drv_rdx(1, 32'h20, 32'hAAAAAAAA);      go();
    wait_n(4);

    // out-of-range read and write: error, no aliasing onto address 0
    drv_wr(1, 32'h0, 4'hF, 32'h0BADF00D);      go();
    drv_rd(0, ABW'(SZ));                       go();
    wait_n(3);
    drv_wr(1, ABW'(SZ), 4'hF, 32'h12345678);   go();
    drv_rdx(0, 32'h0, 32'h0BADF00D);           go();
    wait_n(4);

    // back-to-back reads
    drv_wr(1, 32'h4, 4'hF, 32'h44444444); go();
    drv_wr(1, 32'h8, 4'hF, 32'h88888888); go();
    drv_rdx(0, 32'h0, 32'h0BADF00D); go();
    drv_rdx(0, 32'h4, 32'h44444444); go();
    drv_rdx(0, 32'h8, 32'h88888888); go();
    wait_n(4);

    // reset with reads in flight: rdt returns to 0 and nothing arrives late
    drv_rd(0, 32'h4); go();
    drv_rd(0, 32'h8); go();
    rst = 1'b1; tick();
    rst = 1'b0; wait_n(5);

    // fill a region, then random traffic on both ports
    for (int w = 0; w < 64; w++) begin
      drv_wr(w % 2, ABW'(w * 4), 4'hF, 32'($urandom));
      go();
    end
    for (int n = 0; n < NRND; n++) begin
      for (int p = 0; p < PN; p++) begin
        if (!tcb.vld[p] || acc[p]) begin
          r = $urandom_range(0, 9);
          a = ABW'($urandom_range(0, 63)) << 2;
          if (r < 3)      drv_idle(p);
          else if (r < 6) drv_rd(p, a);
          else if (r < 9) drv_wr(p, a, BEW'($urandom_range(1, 15)), 32'($urandom));
          else            drv_rd(p, ABW'(SZ) + a);
        end
      end
      tick();
    end
    for (int p = 0; p < PN; p++) drv_idle(p);
    wait_n(DLY + 3);
    check("scoreboard_drained", DBW'(sbq.size()), '0);
`ifdef TCB_VIP_MEM_STALL_EN
    check("rdy_duty_40_60", DBW'(rdy_cnt * 100 >= rdy_tot * 40 && rdy_cnt * 100 <= rdy_tot * 60), DBW'(1));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
